aurora_tx_framer: RTL and testbench
===================================

Name: aurora_tx_framer

Overview:
- Producer-side writer for the Aurora TX FIFO; the Aurora data controller drains this FIFO onto the serial link.
- Packs a user payload stream into framed packets: one header word, N payload words, one checksum trailer word.
- Runs in the Aurora user_clk domain.
- The far-end deframer uses header length/sequence and the trailer to validate packets and discard garbage left after a channel reset.

Parameters:
- MAGIC, 16'hA5C3, constant placed in header bits [31:16].
- LEN_W, 8, width of pkt_len. Maximum payload is 2^LEN_W-1 words.

Ports:
- user_clk  in  1  sole clock (Aurora user clock).
- rst  in  1  asynchronous, active-high reset.
- channel_rdy  in  1  Aurora CHANNEL_UP, registered in user_clk.
- start  in  1  single-cycle request to frame one packet.
- pkt_len  in  LEN_W  payload word count, sampled on accepted start.
- src_dat  in  32  payload word.
- src_valid  in  1  src_dat valid.
- src_rdy  out  1  framer accepts src_dat this cycle.
- fifo_wr_dat_o  out  32  TX FIFO write data.
- fifo_wr_o  out  1  TX FIFO write strobe.
- fifo_full_i  in  1  TX FIFO full.
- busy  out  1  state != IDLE.
- pkt_cnt  out  16  completed packets, wraps at 16'hFFFF->0.
- err_abort  out  1  one-cycle pulse: packet aborted by channel drop.
- err_len  out  1  one-cycle pulse: start rejected because pkt_len==0.

Behaviour:
- Reset (async assert, user_clk release) values:
  - state IDLE.
  - src_rdy=0, fifo_wr_o=0, fifo_wr_dat_o=0, busy=0, pkt_cnt=0, err_abort=0, err_len=0.
  - seq=0, sum=0, remaining=0.
- FSM states: IDLE, HDR, PAYLOAD, TRL.
- IDLE:
  - start & channel_rdy & pkt_len!=0 -> latch remaining=pkt_len, clear sum=0, go HDR.
  - start & pkt_len==0 -> err_len=1 next cycle, stay IDLE.
  - start & ~channel_rdy -> ignored, no flag.
  - start while not IDLE -> ignored.
- HDR:
  - fifo_wr_o = ~fifo_full_i (combinational).
  - fifo_wr_dat_o = {MAGIC, seq[7:0], remaining[7:0]}.
  - On write -> PAYLOAD.
- PAYLOAD:
  - src_rdy = ~fifo_full_i; fifo_wr_o = src_valid & ~fifo_full_i; fifo_wr_dat_o = src_dat (zero-latency pass-through).
  - On each write: sum <= sum + src_dat (mod 2^32) and remaining <= remaining-1.
  - Write with remaining==1 -> TRL.
- TRL:
  - fifo_wr_o = ~fifo_full_i; fifo_wr_dat_o = sum.
  - On write: seq <= seq+1 (wraps 255->0), pkt_cnt <= pkt_cnt+1, go IDLE.
- src_rdy=0 in every state except PAYLOAD. No FIFO write ever occurs while fifo_full_i=1.
- Channel drop: channel_rdy=0 in HDR, PAYLOAD or TRL aborts the packet.
  - No write that cycle; go IDLE; err_abort=1 next cycle.
  - No trailer is written. seq and pkt_cnt are not incremented, so the next packet reuses the same seq.
- Simultaneous fifo_full_i and channel drop -> abort takes priority.
- Latency: header is written the cycle after an accepted start, provided the FIFO is not full. A packet of N words with no stalls occupies exactly N+2 write cycles.
- busy is registered from the state; it is 1 from the cycle after start through the TRL write cycle.

Test Plan:
- Basic packet, FIFO never full: start with pkt_len=3, payload 1,2,3.
  - Required FIFO writes on consecutive cycles: A5C3_0003, 1, 2, 3, 6.
  - Then pkt_cnt=1 and the next header carries seq=1.
- Backpressure: pkt_len=4, fifo_full_i held high for 3 cycles mid-payload, plus src_valid gaps.
  - No write while full; payload order is preserved; trailer = arithmetic sum of the 4 words.
- Overflow and wrap: payload words FFFFFFFF and 00000002.
  - Trailer = 00000001.
  - After 256 completed packets, header seq field = 00 again.
- Channel drop: channel_rdy deasserted after the 2nd payload word of a pkt_len=5 packet.
  - err_abort pulses once; no trailer written; state returns to IDLE.
  - Next packet header repeats the same seq; pkt_cnt is unchanged.
- Illegal and ignored starts:
  - start with pkt_len=0 -> err_len pulses, no writes.
  - start while busy -> ignored.
  - start with channel_rdy=0 -> no writes, no flags.
- Asynchronous reset asserted mid-PAYLOAD (between clock edges):
  - All outputs go to their reset values immediately; no further writes.
  - seq and pkt_cnt read 0 after reset.

Source files
------------

// File: rtl/aurora_tx_framer.sv
// aurora_tx_framer: packs a user payload stream into framed packets for the
// Aurora TX FIFO. Each packet is one header word, N payload words and a
// 32-bit additive checksum trailer. Runs entirely in the user_clk domain.
module aurora_tx_framer #(
  parameter logic [15:0] MAGIC = 16'hA5C3,
  parameter int          LEN_W = 8
) (
  input  logic             user_clk,
  input  logic             rst,
  input  logic             channel_rdy,
  input  logic             start,
  input  logic [LEN_W-1:0] pkt_len,
  input  logic [31:0]      src_dat,
  input  logic             src_valid,
  output logic             src_rdy,
  output logic [31:0]      fifo_wr_dat_o,
  output logic             fifo_wr_o,
  input  logic             fifo_full_i,
  output logic             busy,
  output logic [15:0]      pkt_cnt,
  output logic             err_abort,
  output logic             err_len
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2,
    TRL     = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ZERO = LEN_W'(0);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  state_t           state_r;
  logic [7:0]       seq_r;
  logic [31:0]      sum_r;
  logic [LEN_W-1:0] remaining_r;
  logic [15:0]      pkt_cnt_r;
  logic             err_abort_r;
  logic             err_len_r;
  logic [15:0]      rem_ext_s;
  logic             can_wr_s;

  // The header length field is the low byte of the latched word count.
  assign rem_ext_s = 16'(remaining_r);

  // A write slot exists only while the link is up and the FIFO has room;
  // a channel drop therefore wins over a full FIFO and suppresses the write.
  assign can_wr_s = channel_rdy & ~fifo_full_i;

  assign busy      = (state_r != IDLE);
  assign pkt_cnt   = pkt_cnt_r;
  assign err_abort = err_abort_r;
  assign err_len   = err_len_r;

  // FIFO write port and source handshake decoded from the registered state;
  // payload words pass straight through with zero latency.
  always_comb begin
    src_rdy       = 1'b0;
    fifo_wr_o     = 1'b0;
    fifo_wr_dat_o = 32'd0;
    case (state_r)
      IDLE: begin
        src_rdy       = 1'b0;
        fifo_wr_o     = 1'b0;
        fifo_wr_dat_o = 32'd0;
      end
      HDR: begin
        fifo_wr_o     = can_wr_s;
        fifo_wr_dat_o = {MAGIC, seq_r, rem_ext_s[7:0]};
      end
      PAYLOAD: begin
        src_rdy       = can_wr_s;
        fifo_wr_o     = can_wr_s & src_valid;
        fifo_wr_dat_o = src_dat;
      end
      TRL: begin
        fifo_wr_o     = can_wr_s;
        fifo_wr_dat_o = sum_r;
      end
      default: begin
        src_rdy       = 1'b0;
        fifo_wr_o     = 1'b0;
        fifo_wr_dat_o = 32'd0;
      end
    endcase
  end

  // Framing state machine with sequence, checksum, length and status registers.
  always_ff @(posedge user_clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      seq_r       <= 8'd0;
      sum_r       <= 32'd0;
      remaining_r <= LEN_ZERO;
      pkt_cnt_r   <= 16'd0;
      err_abort_r <= 1'b0;
      err_len_r   <= 1'b0;
    end else begin
      err_abort_r <= 1'b0;
      err_len_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start && (pkt_len == LEN_ZERO)) begin
            err_len_r <= 1'b1;
          end else if (start && channel_rdy) begin
            remaining_r <= pkt_len;
            sum_r       <= 32'd0;
            state_r     <= HDR;
          end
        end
        HDR: begin
          if (!channel_rdy) begin
            err_abort_r <= 1'b1;
            state_r     <= IDLE;
          end else if (!fifo_full_i) begin
            state_r <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (!channel_rdy) begin
            err_abort_r <= 1'b1;
            state_r     <= IDLE;
          end else if (src_valid && !fifo_full_i) begin
            sum_r       <= sum_r + src_dat;
            remaining_r <= remaining_r - LEN_ONE;
            if (remaining_r == LEN_ONE) begin
              state_r <= TRL;
            end
          end
        end
        TRL: begin
          if (!channel_rdy) begin
            err_abort_r <= 1'b1;
            state_r     <= IDLE;
          end else if (!fifo_full_i) begin
            seq_r     <= seq_r + 8'd1;
            pkt_cnt_r <= pkt_cnt_r + 16'd1;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aurora_tx_framer.sv
// Self-checking bench for aurora_tx_framer: expected FIFO words are queued
// when a packet is launched and compared as the framer writes them.
module tb_aurora_tx_framer;

  logic        user_clk = 1'b0;
  logic        rst = 1'b1;
  logic        channel_rdy = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  pkt_len = 8'd0;
  logic [31:0] src_dat = 32'd0;
  logic        src_valid = 1'b0;
  logic        src_rdy;
  logic [31:0] fifo_wr_dat_o;
  logic        fifo_wr_o;
  logic        fifo_full_i = 1'b0;
  logic        busy;
  logic [15:0] pkt_cnt;
  logic        err_abort;
  logic        err_len;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q [$];
  logic [31:0] pay [0:15];
  logic [63:0] full_mask = 64'd0;
  logic [63:0] gap_mask = 64'd0;
  logic [7:0]  tb_seq = 8'd0;

  aurora_tx_framer dut (
    .user_clk      (user_clk),
    .rst           (rst),
    .channel_rdy   (channel_rdy),
    .start         (start),
    .pkt_len       (pkt_len),
    .src_dat       (src_dat),
    .src_valid     (src_valid),
    .src_rdy       (src_rdy),
    .fifo_wr_dat_o (fifo_wr_dat_o),
    .fifo_wr_o     (fifo_wr_o),
    .fifo_full_i   (fifo_full_i),
    .busy          (busy),
    .pkt_cnt       (pkt_cnt),
    .err_abort     (err_abort),
    .err_len       (err_len)
  );

  always #5 user_clk = ~user_clk;

  // Scoreboard: every FIFO write must match the next queued word, and no
  // write may happen while the FIFO reports full.
  always @(negedge user_clk) begin
    if (!rst) begin
      if (fifo_wr_o) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write: got %08h, required no write", fifo_wr_dat_o);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (fifo_wr_dat_o !== e) begin
            n_err++;
            $display("FAIL fifo_word: got %08h, required %08h", fifo_wr_dat_o, e);
          end
        end
      end
      if (fifo_full_i) begin
        n_cmp++;
        if (fifo_wr_o !== 1'b0) begin
          n_err++;
          $display("FAIL write_while_full: wr=%b, required 0", fifo_wr_o);
        end
      end
    end
  end

  // Launch one packet and drive its payload, honouring full/gap masks.
  // drop_at >= 0 drops the channel once that many words were accepted.
  task automatic run_packet(input int len, input logic [7:0] eseq, input int drop_at,
                            input bit restart, output int cycles);
    logic [31:0] sum;
    int idx;
    int nwords;
    sum = 32'd0;
    nwords = (drop_at >= 0) ? drop_at : len;
    exp_q.push_back({16'hA5C3, eseq, 8'(len)});
    for (int i = 0; i < nwords; i++) begin
      exp_q.push_back(pay[i]);
      sum = sum + pay[i];
    end
    if (drop_at < 0) exp_q.push_back(sum);
    @(posedge user_clk); #1;
    start = 1'b1;
    pkt_len = 8'(len);
    @(posedge user_clk); #1;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL busy_after_start: got %b, required 1", busy);
    end
    idx = 0;
    cycles = 0;
    while (!(exp_q.size() == 0 && !busy)) begin
      if (cycles > 60) begin
        n_err++;
        $display("FAIL packet_timeout: got %0d queued words, required 0", exp_q.size());
        exp_q.delete();
        break;
      end
      fifo_full_i = full_mask[cycles];
      src_valid = (idx < len) && !gap_mask[cycles];
      src_dat = pay[idx];
      channel_rdy = !(drop_at >= 0 && idx == drop_at);
      if (restart && cycles == 1) begin
        start = 1'b1;
        pkt_len = 8'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge user_clk);
      if (src_rdy && src_valid) idx++;
      @(posedge user_clk); #1;
      cycles++;
      if (!channel_rdy) begin
        n_cmp++;
        if (err_abort !== 1'b1 || busy !== 1'b0) begin
          n_err++;
          $display("FAIL abort_pulse: got err_abort=%b busy=%b, required 1 0", err_abort, busy);
        end
        break;
      end
    end
    start = 1'b0;
    channel_rdy = 1'b1;
    fifo_full_i = 1'b0;
    src_valid = 1'b0;
    full_mask = 64'd0;
    gap_mask = 64'd0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge user_clk);
    #1;
    n_cmp++;
    if ({src_rdy, fifo_wr_o, busy, err_abort, err_len} !== 5'b0 || fifo_wr_dat_o !== 32'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got flags %b dat %08h, required 0", {src_rdy, fifo_wr_o, busy, err_abort, err_len}, fifo_wr_dat_o);
    end
    n_cmp++;
    if (pkt_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL reset_pkt_cnt: got %0d, required 0", pkt_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int cyc;
    pay[0] = 32'd1; pay[1] = 32'd2; pay[2] = 32'd3;
    run_packet(3, tb_seq, -1, 1'b0, cyc);
    tb_seq++;
    n_cmp++;
    if (cyc !== 5) begin
      n_err++;
      $display("FAIL basic_cycles: got %0d, required 5", cyc);
    end
    n_cmp++;
    if (pkt_cnt !== 16'd1) begin
      n_err++;
      $display("FAIL basic_pkt_cnt: got %0d, required 1", pkt_cnt);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    for (int i = 0; i < 4; i++) pay[i] = $urandom();
    full_mask = 64'b0001_1100;
    gap_mask = 64'b0100_0010;
    run_packet(4, tb_seq, -1, 1'b0, cyc);
    tb_seq++;
    n_cmp++;
    if (pkt_cnt !== 16'd2) begin
      n_err++;
      $display("FAIL bp_pkt_cnt: got %0d, required 2", pkt_cnt);
    end
  endtask

  task automatic test_overflow_wrap();
    int cyc;
    pay[0] = 32'hFFFF_FFFF; pay[1] = 32'h0000_0002;
    // Trailer of this packet must be 32'h00000001 (sum modulo 2^32).
    run_packet(2, tb_seq, -1, 1'b0, cyc);
    tb_seq++;
    for (int k = 3; k < 256; k++) begin
      pay[0] = 32'(k * 7);
      run_packet(1, tb_seq, -1, 1'b0, cyc);
      tb_seq++;
    end
    n_cmp++;
    if (pkt_cnt !== 16'd256) begin
      n_err++;
      $display("FAIL wrap_pkt_cnt: got %0d, required 256", pkt_cnt);
    end
  endtask

  task automatic test_channel_drop();
    int cyc;
    for (int i = 0; i < 5; i++) pay[i] = 32'h1000 + 32'(i);
    run_packet(5, tb_seq, 2, 1'b0, cyc);
    @(posedge user_clk); #1;
    n_cmp++;
    if (err_abort !== 1'b0 || busy !== 1'b0 || pkt_cnt !== 16'd256) begin
      n_err++;
      $display("FAIL drop_after: got err_abort=%b busy=%b cnt=%0d, required 0 0 256", err_abort, busy, pkt_cnt);
    end
    pay[0] = 32'hCAFE_0001;
    run_packet(1, tb_seq, -1, 1'b0, cyc);
    tb_seq++;
    n_cmp++;
    if (pkt_cnt !== 16'd257) begin
      n_err++;
      $display("FAIL drop_next_cnt: got %0d, required 257", pkt_cnt);
    end
  endtask

  task automatic test_illegal_starts();
    int cyc;
    @(posedge user_clk); #1;
    start = 1'b1; pkt_len = 8'd0;
    @(posedge user_clk); #1;
    start = 1'b0;
    n_cmp++;
    if (err_len !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL len0_pulse: got err_len=%b busy=%b, required 1 0", err_len, busy);
    end
    @(posedge user_clk); #1;
    n_cmp++;
    if (err_len !== 1'b0) begin
      n_err++;
      $display("FAIL len0_once: got %b, required 0", err_len);
    end
    channel_rdy = 1'b0;
    start = 1'b1; pkt_len = 8'd3;
    @(posedge user_clk); #1;
    start = 1'b0;
    @(posedge user_clk); #1;
    channel_rdy = 1'b1;
    n_cmp++;
    if ({busy, err_len, err_abort} !== 3'b000) begin
      n_err++;
      $display("FAIL start_no_channel: got busy/len/abort=%b, required 000", {busy, err_len, err_abort});
    end
    for (int i = 0; i < 3; i++) pay[i] = 32'hBEEF_0000 + 32'(i);
    run_packet(3, tb_seq, -1, 1'b1, cyc);
    tb_seq++;
    @(posedge user_clk); #1;
    n_cmp++;
    if (busy !== 1'b0 || pkt_cnt !== 16'd258) begin
      n_err++;
      $display("FAIL start_while_busy: got busy=%b cnt=%0d, required 0 258", busy, pkt_cnt);
    end
  endtask

  task automatic test_async_reset();
    int idx;
    int cyc;
    for (int i = 0; i < 4; i++) pay[i] = 32'h5500_0000 + 32'(i);
    exp_q.push_back({16'hA5C3, tb_seq, 8'd4});
    exp_q.push_back(pay[0]);
    exp_q.push_back(pay[1]);
    @(posedge user_clk); #1;
    start = 1'b1; pkt_len = 8'd4;
    @(posedge user_clk); #1;
    start = 1'b0;
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      src_valid = 1'b1;
      src_dat = pay[idx];
      @(negedge user_clk);
      if (src_rdy && src_valid) idx++;
      if (idx == 2) break;
      @(posedge user_clk); #1;
    end
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    n_cmp++;
    if ({src_rdy, fifo_wr_o, busy, err_abort, err_len} !== 5'b0 || fifo_wr_dat_o !== 32'd0 || pkt_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL async_reset: got flags %b dat %08h cnt %0d, required 0", {src_rdy, fifo_wr_o, busy, err_abort, err_len}, fifo_wr_dat_o, pkt_cnt);
    end
    src_valid = 1'b0;
    @(posedge user_clk); #1;
    rst = 1'b0;
    tb_seq = 8'd0;
    pay[0] = 32'h0000_0011; pay[1] = 32'h0000_0022;
    run_packet(2, tb_seq, -1, 1'b0, cyc);
    tb_seq++;
    n_cmp++;
    if (pkt_cnt !== 16'd1) begin
      n_err++;
      $display("FAIL post_reset_cnt: got %0d, required 1", pkt_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow_wrap();
    test_channel_drop();
    test_illegal_starts();
    test_async_reset();
    repeat (3) @(posedge user_clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover_words: got %0d, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
